echo_tof_meter: RTL and testbench

//  Acoustic time-of-flight front end for the temperature path. On request it fires one transmit burst.
//  It then counts clock cycles until the first valid rising edge on the reference receiver and on the echo receiver.
//  It presents both counts as N_ref / N_echo and pulses strt, which drives the qdiv/qmult temperature stage directly.

---
 rtl/tof_pkg.sv | 16 +
 rtl/rx_edge_sync.sv | 29 ++
 rtl/echo_tof_meter.sv | 123 ++++++++++++
 tb/tb_echo_tof_meter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tof_pkg.sv
// Shared types and constants for the acoustic time-of-flight front end.
package tof_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    IDLE,
    TX,
    LISTEN,
    DONE,
    ERR
  } state_t;

  // Input-to-rise latency of rx_edge_sync in clk cycles (common to both receivers)
  localparam int unsigned SYNC_LAT = 3;

endpackage

// File: rtl/rx_edge_sync.sv
// Synchronizes an asynchronous comparator output and flags its rising edge.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   async_in asynchronous receiver comparator
//   rise     one-cycle pulse, SYNC_LAT cycles after async_in goes high
module rx_edge_sync
  import tof_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  // Two metastability flops followed by one delay flop used for edge detection
  logic [SYNC_LAT-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_LAT-2:0], async_in};
      rise   <= sync_q[SYNC_LAT-2] & ~sync_q[SYNC_LAT-1];
    end
  end

endmodule

// File: rtl/echo_tof_meter.sv
// Fires one transmit burst per request and counts cycles to the first valid
// rising edge on the reference and echo receivers; pulses strt when both are in.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   meas_start         one-cycle measurement request (ignored while busy)
//   ref_rx, echo_rx    asynchronous receiver comparators
//   tx_out             transmit burst enable
//   N_ref, N_echo      {1'b0, count} time-of-flight results
//   strt               one-cycle pulse: both counts fresh from the same burst
//   busy               measurement in progress
//   err_timeout        sticky timeout flag, cleared by the next accepted request
module echo_tof_meter
  import tof_pkg::*;
#(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned PULSE_CYC = 40,
  parameter int unsigned BLANK     = 200,
  parameter int unsigned TIMEOUT   = 2_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            meas_start,
  input  logic            ref_rx,
  input  logic            echo_rx,
  output logic            tx_out,
  output logic [SIZE-1:0] N_ref,
  output logic [SIZE-1:0] N_echo,
  output logic            strt,
  output logic            busy,
  output logic            err_timeout
);

  localparam int unsigned CW = SIZE - 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] BLANK_C    = CW'(BLANK);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] tof_q;
  logic [CW-1:0] n_ref_q, n_echo_q;
  logic          got_ref_q, got_echo_q;
  logic          ref_rise, echo_rise;
  logic          listening_c, cap_ref_c, cap_echo_c;

  rx_edge_sync u_ref_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ref_rx),
    .rise     (ref_rise)
  );

  rx_edge_sync u_echo_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (echo_rx),
    .rise     (echo_rise)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and capture strobes; a capture in the timeout cycle still counts
  always_comb begin
    state_d     = state_q;
    listening_c = (state_q == TX) || (state_q == LISTEN);
    cap_ref_c   = listening_c && ref_rise  && !got_ref_q  && (tof_q >= BLANK_C);
    cap_echo_c  = listening_c && echo_rise && !got_echo_q && (tof_q >= BLANK_C);
    case (state_q)
      IDLE: if (meas_start) state_d = TX;
      TX, LISTEN: begin
        if ((got_ref_q || cap_ref_c) && (got_echo_q || cap_echo_c)) state_d = DONE;
        else if (tof_q == TMO_LAST)                                  state_d = ERR;
        else if ((state_q == TX) && (tof_q == PULSE_LAST))           state_d = LISTEN;
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counter, capture registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tof_q       <= '0;
      n_ref_q     <= '0;
      n_echo_q    <= '0;
      got_ref_q   <= 1'b0;
      got_echo_q  <= 1'b0;
      tx_out      <= 1'b0;
      busy        <= 1'b0;
      strt        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if ((state_q == IDLE) && meas_start) begin
        tof_q       <= '0;
        got_ref_q   <= 1'b0;
        got_echo_q  <= 1'b0;
        err_timeout <= 1'b0;
      end else if (listening_c) begin
        // Bounded by TIMEOUT < 2^CW, so this never wraps
        tof_q <= tof_q + CW'(1);
      end
      if (cap_ref_c) begin
        n_ref_q   <= tof_q;
        got_ref_q <= 1'b1;
      end
      if (cap_echo_c) begin
        n_echo_q   <= tof_q;
        got_echo_q <= 1'b1;
      end
      if (state_d == ERR) err_timeout <= 1'b1;
      tx_out <= (state_d == TX);
      busy   <= (state_d == TX) || (state_d == LISTEN);
      strt   <= (state_d == DONE);
    end
  end

  assign N_ref  = {1'b0, n_ref_q};
  assign N_echo = {1'b0, n_echo_q};

endmodule

// File: tb/tb_echo_tof_meter.sv
// Bench for echo_tof_meter: event-level model of each measurement, checked every cycle.
module tb_echo_tof_meter;

  localparam int PULSE = 40;
  localparam int BLANK = 200;
  localparam int LAT   = 3;
  localparam int TMO_A = 5000;
  localparam int TMO_B = 32767;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ms_a, ms_b, ref_rx, echo_rx;
  logic tx_a, strt_a, busy_a, err_a;
  logic [31:0] nref_a, necho_a;
  logic tx_b, strt_b, busy_b, err_b;
  logic [15:0] nref_b, necho_b;

  echo_tof_meter #(.SIZE(32), .PULSE_CYC(PULSE), .BLANK(BLANK), .TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .rst(rst), .meas_start(ms_a), .ref_rx(ref_rx), .echo_rx(echo_rx),
    .tx_out(tx_a), .N_ref(nref_a), .N_echo(necho_a), .strt(strt_a), .busy(busy_a),
    .err_timeout(err_a)
  );

  echo_tof_meter #(.SIZE(16), .PULSE_CYC(PULSE), .BLANK(BLANK), .TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .rst(rst), .meas_start(ms_b), .ref_rx(ref_rx), .echo_rx(echo_rx),
    .tx_out(tx_b), .N_ref(nref_b), .N_echo(necho_b), .strt(strt_b), .busy(busy_b),
    .err_timeout(err_b)
  );

  int errors = 0;
  int checks = 0;
  int cur_t  = -1;

  // Model outputs for the current cycle
  bit   chk_en = 1'b0;
  bit   sel_b  = 1'b0;
  logic exp_tx, exp_busy, exp_strt, exp_err;
  int   exp_nref, exp_necho;
  int   prev_r, prev_e;

  // Receiver waveforms relative to t: pulse i is high from rise[i] to fall[i]-1 (fall<0 = held)
  int rr[$], rf[$], er[$], ef[$];
  int strt_cnt, strt_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d expected %0d", name, cur_t, act, exp);
    end
  endtask

  function automatic logic lvl(input bit is_ref, input int t);
    int rs[$];
    int fs[$];
    logic v;
    rs = is_ref ? rr : er;
    fs = is_ref ? rf : ef;
    v = 1'b0;
    foreach (rs[i]) if (rs[i] <= t && (fs[i] < 0 || t < fs[i])) v = 1'b1;
    return v;
  endfunction

  // Count latched for a channel: first rise seen past blanking and before the deadline
  function automatic int first_cap(input bit is_ref, input int tmo);
    int rs[$];
    rs = is_ref ? rr : er;
    foreach (rs[i]) if (rs[i] + LAT >= BLANK && rs[i] + LAT <= tmo - 1) return rs[i] + LAT;
    return -1;
  endfunction

  // Single compare process
  always @(negedge clk) begin
    if (chk_en) begin
      if (sel_b) begin
        check("tx_out", 32'(tx_b), 32'(exp_tx));
        check("busy", 32'(busy_b), 32'(exp_busy));
        check("strt", 32'(strt_b), 32'(exp_strt));
        check("err_timeout", 32'(err_b), 32'(exp_err));
        check("N_ref", 32'(nref_b), 32'(exp_nref));
        check("N_echo", 32'(necho_b), 32'(exp_necho));
        check("msb16", 32'(nref_b[15] | necho_b[15]), 32'd0);
      end else begin
        check("tx_out", 32'(tx_a), 32'(exp_tx));
        check("busy", 32'(busy_a), 32'(exp_busy));
        check("strt", 32'(strt_a), 32'(exp_strt));
        check("err_timeout", 32'(err_a), 32'(exp_err));
        check("N_ref", nref_a, 32'(exp_nref));
        check("N_echo", necho_a, 32'(exp_necho));
        check("msb32", 32'(nref_a[31] | necho_a[31]), 32'd0);
      end
    end
  end

  task automatic run_meas(input bit use_b, input int tmo, input int extra_ms_t, input int abort_t);
    int  cr, ce, tend;
    bit  done;
    cr   = first_cap(1'b1, tmo);
    ce   = first_cap(1'b0, tmo);
    done = (cr >= 0) && (ce >= 0);
    tend = done ? ((cr > ce ? cr : ce) + 1) : tmo;
    strt_cnt = 0;
    strt_t   = -1;
    @(posedge clk); #1;
    if (use_b) ms_b = 1'b1; else ms_a = 1'b1;
    @(posedge clk); #1;
    ms_a = 1'b0;
    ms_b = 1'b0;
    for (int t = 0; t <= tend + 1; t++) begin
      cur_t     = t;
      exp_tx    = (t < PULSE);
      exp_busy  = (t < tend);
      exp_strt  = done && (t == tend);
      exp_err   = !done && (t >= tend);
      exp_nref  = (cr >= 0 && t > cr) ? cr : prev_r;
      exp_necho = (ce >= 0 && t > ce) ? ce : prev_e;
      if (t == abort_t) begin
        chk_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_tx_out", 32'(tx_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_N_ref", nref_a, 32'd0);
        check("rst_N_echo", necho_a, 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        ref_rx = 1'b0;
        echo_rx = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        prev_r = 0; prev_e = 0;
        exp_tx = 1'b0; exp_busy = 1'b0; exp_strt = 1'b0; exp_err = 1'b0;
        exp_nref = 0; exp_necho = 0;
        chk_en = 1'b1;
        return;
      end
      if (use_b ? strt_b : strt_a) begin
        strt_cnt++;
        strt_t = t;
      end
      ref_rx  = lvl(1'b1, t);
      echo_rx = lvl(1'b0, t);
      if (!use_b) ms_a = (t == extra_ms_t);
      @(posedge clk); #1;
    end
    ms_a = 1'b0;
    if (cr >= 0) prev_r = cr;
    if (ce >= 0) prev_e = ce;
    ref_rx  = 1'b0;
    echo_rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ms_a = 1'b0; ms_b = 1'b0; ref_rx = 1'b0; echo_rx = 1'b0;
    exp_tx = 1'b0; exp_busy = 1'b0; exp_strt = 1'b0; exp_err = 1'b0;
    exp_nref = 0; exp_necho = 0; prev_r = 0; prev_e = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_out", 32'(tx_a), 32'd0);
    check("reset_strt", 32'(strt_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_N_ref", nref_a, 32'd0);
    @(negedge clk) rst = 1'b1;
    chk_en = 1'b1;

    // Normal ordering
    rr = '{1000}; rf = '{-1}; er = '{1100}; ef = '{-1};
    run_meas(1'b0, TMO_A, -1, -1);
    check("t1_N_ref", nref_a, 32'd1003);
    check("t1_N_echo", necho_a, 32'd1103);
    check("t1_strt_cnt", 32'(strt_cnt), 32'd1);
    check("t1_strt_t", 32'(strt_t), 32'd1104);

    // Echo before ref, then simultaneous
    rr = '{700}; rf = '{-1}; er = '{500}; ef = '{-1};
    run_meas(1'b0, TMO_A, -1, -1);
    check("t2_N_ref", nref_a, 32'd703);
    check("t2_N_echo", necho_a, 32'd503);
    check("t2_strt_cnt", 32'(strt_cnt), 32'd1);
    rr = '{800}; er = '{800};
    run_meas(1'b0, TMO_A, -1, -1);
    check("t2s_N_ref", nref_a, 32'd803);
    check("t2s_N_echo", necho_a, 32'd803);

    // Blanked edge and repeated edges
    rr = '{50, 300}; rf = '{61, -1}; er = '{400, 450}; ef = '{420, -1};
    run_meas(1'b0, TMO_A, -1, -1);
    check("t3_N_ref", nref_a, 32'd303);
    check("t3_N_echo", necho_a, 32'd403);

    // Timeout with only the reference arriving
    rr = '{1000}; rf = '{-1}; er.delete(); ef.delete();
    run_meas(1'b0, TMO_A, -1, -1);
    check("t4_err", 32'(err_a), 32'd1);
    check("t4_N_ref", nref_a, 32'd1003);
    check("t4_N_echo", necho_a, 32'd403);
    check("t4_strt_cnt", 32'(strt_cnt), 32'd0);

    // Request while listening is ignored; new request clears the error
    rr = '{600}; rf = '{-1}; er = '{650}; ef = '{-1};
    run_meas(1'b0, TMO_A, 300, -1);
    check("t5_err", 32'(err_a), 32'd0);
    check("t5_N_ref", nref_a, 32'd603);
    check("t5_N_echo", necho_a, 32'd653);
    check("t5_strt_t", 32'(strt_t), 32'd654);

    // Reset mid-burst, then a fresh measurement
    rr.delete(); rf.delete(); er.delete(); ef.delete();
    run_meas(1'b0, TMO_A, -1, 20);
    rr = '{250}; rf = '{-1}; er = '{260}; ef = '{-1};
    run_meas(1'b0, TMO_A, -1, -1);
    check("t5r_N_ref", nref_a, 32'd253);
    check("t5r_N_echo", necho_a, 32'd263);

    // 16-bit instance timing out at the largest count
    prev_r = 0; prev_e = 0;
    exp_nref = 0; exp_necho = 0; exp_err = 1'b0; exp_busy = 1'b0; exp_strt = 1'b0; exp_tx = 1'b0;
    sel_b = 1'b1;
    rr = '{1000}; rf = '{-1}; er.delete(); ef.delete();
    run_meas(1'b1, TMO_B, -1, -1);
    check("t6_err", 32'(err_b), 32'd1);
    check("t6_N_ref", 32'(nref_b), 32'd1003);
    check("t6_N_echo", 32'(necho_b), 32'd0);
    check("t6_strt_cnt", 32'(strt_cnt), 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
